ball_motion_sched: RTL and testbench

- Per-frame motion scheduler for N bouncing sprites drawn by the VGA pixel path.
- Detects the vblank rising edge synchronously in the clk domain; no edge-clocked `posedge vblank` logic.
- Then walks each ball in turn through a small FSM, applying speed, bounce and direction rules.
- Exports flattened position/direction buses for the pixel compare logic, plus pause/single-step debug controls and status.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/ball_axis_step.sv | 56 +++++
 rtl/ball_motion_sched.sv | 197 +++++++++++++++++++
 tb/tb_ball_motion_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA sprite path: screen size
// defaults, coordinate width, direction encoding and the motion
// scheduler's state encoding.
package vga_pkg;

    // Visible screen size defaults.
    localparam int HPIXELS_DEF = 640;
    localparam int VPIXELS_DEF = 480;

    // Width of every sprite coordinate.
    localparam int COORD_W = 11;

    // Direction encoding used on both axes.
    // Forward is right (h) or down (v). Back is left (h) or up (v).
    localparam logic DIR_FWD  = 1'b0;
    localparam logic DIR_BACK = 1'b1;

    // Motion scheduler states. HORZ and VERT are visited once per ball.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HORZ = 2'd1,
        ST_VERT = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// Single-axis step-and-bounce for one sprite coordinate.
// Purely combinational. The scheduler shares one instance between
// its horizontal and vertical phases.
// All sums are carried at COORD_W+1 bits so the wall test cannot wrap.
module ball_axis_step
    import vga_pkg::*;
#(
    parameter int BALL_SIZE = 8
) (
    input  logic [COORD_W-1:0] i_p,
    input  logic               i_d,
    input  logic [3:0]         i_spd,
    input  logic [COORD_W-1:0] i_max,
    output logic [COORD_W-1:0] o_p,
    output logic               o_d,
    output logic               o_flip
);

    logic [COORD_W:0] w_p_ext;
    logic [COORD_W:0] w_spd_ext;
    logic [COORD_W:0] w_max_ext;
    logic [COORD_W:0] w_fwd_sum;
    logic             w_spd_zero;
    logic             w_hit;

    // Wall test for the current direction. A zero speed never moves and never bounces.
    always_comb begin
        w_p_ext    = {1'b0, i_p};
        w_spd_ext  = (COORD_W+1)'(i_spd);
        w_max_ext  = {1'b0, i_max};
        w_fwd_sum  = w_p_ext + (COORD_W+1)'(BALL_SIZE) + w_spd_ext;
        w_spd_zero = (i_spd == 4'd0);

        if (i_d == DIR_FWD) begin
            // The far edge of the sprite would reach or pass the limit.
            w_hit = !w_spd_zero && (w_fwd_sum >= w_max_ext);
        end else begin
            // Moving back would go below coordinate zero.
            w_hit = !w_spd_zero && (w_p_ext < w_spd_ext);
        end
    end

    // Next position and direction. On a bounce the position is held for this frame.
    always_comb begin
        o_flip = w_hit;
        o_d    = w_hit ? ~i_d : i_d;
        if (w_hit || w_spd_zero) begin
            o_p = i_p;
        end else if (i_d == DIR_FWD) begin
            o_p = i_p + COORD_W'(i_spd);
        end else begin
            o_p = i_p - COORD_W'(i_spd);
        end
    end

endmodule

// File: rtl/ball_motion_sched.sv
// Per-frame motion scheduler for N bouncing sprites.
//
// A vblank rising edge is detected in the clk domain and registered.
// One cycle later the FSM accepts it. It then steps each ball through
// HORZ (x / h_dir) and VERT (y / v_dir), one ball after another.
// A single ball_axis_step instance is muxed between the two axes.
// This means at most one bounce can happen per cycle.
//
// Interface contract:
//   Frame start is the registered rise of vblank, seen once per edge.
//   It is accepted only in IDLE, and only if pause is low or a step is armed.
//   A frame start that arrives in any other state is dropped and sets overrun.
//   busy is high from the first HORZ through DONE.
//   frame_done pulses for one cycle in DONE.
//   At that point every position and direction output holds the new frame's values.
module ball_motion_sched
    import vga_pkg::*;
#(
    parameter int N_BALLS   = 4,
    parameter int BALL_SIZE = 8,
    parameter int HPIXELS   = HPIXELS_DEF,
    parameter int VPIXELS   = VPIXELS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vblank,
    input  logic [3:0]                   speed,
    input  logic                         pause,
    input  logic                         step,
    output logic [COORD_W*N_BALLS-1:0]   ball_x,
    output logic [COORD_W*N_BALLS-1:0]   ball_y,
    output logic [2*N_BALLS-1:0]         ball_dir,
    output logic                         busy,
    output logic                         frame_done,
    output logic [15:0]                  bounce_cnt,
    output logic                         overrun,
    output sched_state_t                 dbg_state
);

    localparam int IDX_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BALLS - 1);

    // Edge detection.
    logic                r_vblank_q;
    logic                r_rise;
    logic                w_rise;

    // Scheduler state.
    sched_state_t        r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [3:0]          r_spd;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_step_armed;
    logic                r_overrun;
    logic [15:0]         r_bounce_cnt;

    // Per-ball positions and directions.
    logic [COORD_W-1:0]  r_x    [N_BALLS];
    logic [COORD_W-1:0]  r_y    [N_BALLS];
    logic                r_hdir [N_BALLS];
    logic                r_vdir [N_BALLS];

    // Shared axis step.
    logic                w_is_vert;
    logic                w_active;
    logic [COORD_W-1:0]  w_p;
    logic                w_d;
    logic [COORD_W-1:0]  w_max;
    logic [COORD_W-1:0]  w_p_next;
    logic                w_d_next;
    logic                w_flip;

    assign w_rise = vblank & ~r_vblank_q;

    // Register vblank every cycle and hold the rise for the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblank_q <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_vblank_q <= vblank;
            r_rise     <= w_rise;
        end
    end

    // Select the axis operands for the ball currently being processed.
    always_comb begin
        w_is_vert = (r_state == ST_VERT);
        w_active  = (r_state == ST_HORZ) || (r_state == ST_VERT);
        w_p       = w_is_vert ? r_y[r_idx]    : r_x[r_idx];
        w_d       = w_is_vert ? r_vdir[r_idx] : r_hdir[r_idx];
        w_max     = w_is_vert ? COORD_W'(VPIXELS) : COORD_W'(HPIXELS);
    end

    ball_axis_step #(
        .BALL_SIZE (BALL_SIZE)
    ) u_axis (
        .i_p    (w_p),
        .i_d    (w_d),
        .i_spd  (r_spd),
        .i_max  (w_max),
        .o_p    (w_p_next),
        .o_d    (w_d_next),
        .o_flip (w_flip)
    );

    // Scheduler FSM: frame accept, per-ball axis walk, and pause/step/overrun bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_spd        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_step_armed <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < N_BALLS; i++) begin
                r_x[i]    <= COORD_W'(16 + 64 * i);
                r_y[i]    <= COORD_W'(16 + 48 * i);
                r_hdir[i] <= i[0];
                r_vdir[i] <= i[1];
            end
        end else begin
            r_frame_done <= 1'b0;

            // A step arms one update only while paused.
            if (pause && step) begin
                r_step_armed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_rise && (!pause || r_step_armed)) begin
                        r_spd        <= speed;
                        r_idx        <= '0;
                        r_step_armed <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_HORZ;
                    end
                end
                ST_HORZ: begin
                    r_x[r_idx]    <= w_p_next;
                    r_hdir[r_idx] <= w_d_next;
                    r_state       <= ST_VERT;
                end
                ST_VERT: begin
                    r_y[r_idx]    <= w_p_next;
                    r_vdir[r_idx] <= w_d_next;
                    if (r_idx == LAST_IDX) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_HORZ;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            // A frame start that arrives mid-sequence is dropped but remembered.
            if (r_rise && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Count direction flips, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bounce_cnt <= '0;
        end else if (w_active && w_flip && (r_bounce_cnt != 16'hFFFF)) begin
            r_bounce_cnt <= r_bounce_cnt + 16'd1;
        end
    end

    // Flatten per-ball registers onto the pixel-compare buses.
    for (genvar g = 0; g < N_BALLS; g++) begin : g_flat
        assign ball_x[COORD_W*g +: COORD_W] = r_x[g];
        assign ball_y[COORD_W*g +: COORD_W] = r_y[g];
        assign ball_dir[2*g +: 2]           = {r_vdir[g], r_hdir[g]};
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign bounce_cnt = r_bounce_cnt;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Bench for ball_motion_sched (N_BALLS = 4, 640x480, BALL_SIZE = 8).
// Each accepted frame pushes the model's expected bus state. That state is
// popped and compared when frame_done is seen. Multi-cycle corners are
// checked by hand-written sequences.
module tb_ball_motion_sched;
    import vga_pkg::*;

    localparam int N  = 4;
    localparam int EW = 2 * 11 * N + 2 * N + 16;

    typedef struct {
        logic [3:0] speed;
        logic       pause;
        logic       step;
        logic       exp_update;
    } vec_t;

    // Clock and DUT signals.
    logic              clk = 1'b0;
    logic              rst_n;
    logic              vblank;
    logic [3:0]        speed;
    logic              pause;
    logic              step;
    logic [11*N-1:0]   ball_x;
    logic [11*N-1:0]   ball_y;
    logic [2*N-1:0]    ball_dir;
    logic              busy;
    logic              frame_done;
    logic [15:0]       bounce_cnt;
    logic              overrun;
    sched_state_t      dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [EW-1:0] exp_q[$];
    vec_t          vecs[$];

    // Reference model state.
    int m_x[N];
    int m_y[N];
    bit m_h[N];
    bit m_v[N];
    int m_bounce;

    always #5 clk = ~clk;

    ball_motion_sched #(
        .N_BALLS   (N),
        .BALL_SIZE (8),
        .HPIXELS   (640),
        .VPIXELS   (480)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblank     (vblank),
        .speed      (speed),
        .pause      (pause),
        .step       (step),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_dir   (ball_dir),
        .busy       (busy),
        .frame_done (frame_done),
        .bounce_cnt (bounce_cnt),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 16 + 64 * i;
            m_y[i] = 16 + 48 * i;
            m_h[i] = i[0];
            m_v[i] = i[1];
        end
        m_bounce = 0;
    endtask

    task automatic model_axis(input int p, input bit d, input int spd, input int lim,
                              output int np, output bit nd, output bit fl);
        np = p;
        nd = d;
        fl = 1'b0;
        if (spd != 0) begin
            if (d == 1'b0) begin
                if (p + 8 + spd >= lim) fl = 1'b1;
                else np = p + spd;
            end else begin
                if (p < spd) fl = 1'b1;
                else np = p - spd;
            end
            if (fl) nd = ~d;
        end
    endtask

    task automatic model_frame(input int spd);
        int np;
        bit nd;
        bit fl;
        for (int i = 0; i < N; i++) begin
            model_axis(m_x[i], m_h[i], spd, 640, np, nd, fl);
            m_x[i] = np;
            m_h[i] = nd;
            if (fl && m_bounce < 65535) m_bounce++;
            model_axis(m_y[i], m_v[i], spd, 480, np, nd, fl);
            m_y[i] = np;
            m_v[i] = nd;
            if (fl && m_bounce < 65535) m_bounce++;
        end
    endtask

    function automatic logic [EW-1:0] model_pack();
        logic [11*N-1:0] xb;
        logic [11*N-1:0] yb;
        logic [2*N-1:0]  db;
        for (int i = 0; i < N; i++) begin
            xb[11*i +: 11] = 11'(m_x[i]);
            yb[11*i +: 11] = 11'(m_y[i]);
            db[2*i +: 2]   = {m_v[i], m_h[i]};
        end
        return {xb, yb, db, 16'(m_bounce)};
    endfunction

    // Scoreboard: compare bus state at every frame_done.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL frame_done_unexpected: got pulse required none");
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("frame_state", {ball_x, ball_y, ball_dir, bounce_cnt}, e);
            end
        end
    end

    // Wait (bounded) until every pushed frame is consumed and the DUT is idle.
    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: got queue %0d busy %b required queue 0 busy 0", name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    // Apply one table record: optional step pulse, then one vblank rise.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        speed = v.speed;
        pause = v.pause;
        if (v.step) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        @(negedge clk);
        if (v.exp_update) begin
            model_frame(v.speed);
            exp_q.push_back(model_pack());
        end
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        wait_idle("vec");
        check("vec_state", {ball_x, ball_y, ball_dir, bounce_cnt}, model_pack());
    endtask

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int done_edge;
        int busy_cycles;
        bit ok;

        rst_n  = 1'b0;
        vblank = 1'b0;
        speed  = 4'd0;
        pause  = 1'b0;
        step   = 1'b0;
        model_reset();

        // Stimulus table.
        for (int i = 0; i < 6; i++) vecs.push_back('{4'd15, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'd15, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'd15, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{4'd15, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'd7,  1'b0, 1'b1, 1'b1});
        vecs.push_back('{4'd7,  1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 20; i++) vecs.push_back('{4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1});

        // Reset values, checked while reset is held.
        repeat (3) @(negedge clk);
        check("rst_x",   ball_x,   {11'd208, 11'd144, 11'd80, 11'd16});
        check("rst_y",   ball_y,   {11'd160, 11'd112, 11'd64, 11'd16});
        check("rst_dir", ball_dir, 8'b11_10_01_00);
        check("rst_ctl", {busy, frame_done, overrun, bounce_cnt}, 19'd0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;

        // Latency and busy width for one speed-4 frame.
        @(negedge clk);
        speed = 4'd4;
        model_frame(4);
        exp_q.push_back(model_pack());
        vblank = 1'b1;
        edges = 0;
        done_edge = -1;
        busy_cycles = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) vblank = 1'b0;
            if (frame_done === 1'b1 && done_edge < 0) done_edge = edges - 1;
            if (busy === 1'b1) busy_cycles++;
        end
        check("lat_done_edge", 32'(done_edge), 32'd9);
        check("lat_busy_cycles", 32'(busy_cycles), 32'd9);
        check("f1_x", ball_x, {11'd204, 11'd148, 11'd76, 11'd20});
        check("f1_y", ball_y, {11'd156, 11'd108, 11'd68, 11'd20});
        check("f1_dir_bounce", {ball_dir, bounce_cnt}, {8'b11_10_01_00, 16'd0});
        wait_idle("lat");

        // Table-driven frames from a fresh reset.
        reset_dut();
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
            if (i == 5) begin
                check("s15_b1_x",    ball_x[21:11], 11'd5);
                check("s15_b1_hdir", ball_dir[2],   1'b0);
                check("s15_bounce",  bounce_cnt,    16'd1);
                check("s15_b0_xy",   {ball_x[10:0], ball_y[10:0]}, {11'd106, 11'd106});
            end
        end

        // Overrun: second rise 3 cycles after the first, speed changed mid-sequence.
        reset_dut();
        @(negedge clk);
        speed = 4'd4;
        model_frame(4);
        exp_q.push_back(model_pack());
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        @(negedge clk);
        check("ovr_before", overrun, 1'b0);
        @(negedge clk);
        vblank = 1'b1;
        speed = 4'd9;
        @(negedge clk);
        vblank = 1'b0;
        wait_idle("ovr");
        check("ovr_sticky", overrun, 1'b1);
        check("ovr_state", {ball_x, ball_y, ball_dir, bounce_cnt}, model_pack());
        @(negedge clk);
        model_frame(9);
        exp_q.push_back(model_pack());
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        wait_idle("ovr_next");
        check("ovr_still_set", overrun, 1'b1);

        // Asynchronous reset during VERT(2), then a clean frame.
        reset_dut();
        @(negedge clk);
        speed = 4'd4;
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_busy_seen", ok, 1'b1);
        repeat (5) @(negedge clk);
        check("mid_in_vert", dbg_state, ST_VERT);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_x",   ball_x,   {11'd208, 11'd144, 11'd80, 11'd16});
        check("mid_rst_y",   ball_y,   {11'd160, 11'd112, 11'd64, 11'd16});
        check("mid_rst_ctl", {ball_dir, busy, frame_done, overrun, bounce_cnt, dbg_state},
              {8'b11_10_01_00, 3'b000, 16'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        run_vec('{4'd4, 1'b0, 1'b0, 1'b1});
        check("post_rst_x", ball_x, {11'd204, 11'd148, 11'd76, 11'd20});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
